dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory load/store interface. It accepts one request at a time over a valid/ready handshake. It applies a configurable number of wait states, then performs a byte, halfword or word access on an internal word array, including lane steering and sign or zero extension. It returns the result over a valid/ready response channel, allowing the pipeline to be tested against a memory with non-zero latency.

Parameters:
ADDR_WIDTH, 10, byte-address width; the array holds 2^(ADDR_WIDTH-2) 32-bit words
WORD_WIDTH, 32, data word width; fixed at 32, any other value is unsupported
WAIT_CYCLES, 2, wait states between request accept and access commit; range 0..15

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_wen  input  1  1 = store, 0 = load
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  WORD_WIDTH  store data; the low bytes are used for SB/SH
req_byt_typ  input  3  access type in funct3 encoding
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  WORD_WIDTH  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned access or illegal byt_typ

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not affected by reset.
- byt_typ encoding:
  - 000 = B (signed)
  - 001 = H (signed)
  - 010 = W
  - 100 = BU
  - 101 = HU
  - 011, 110, 111 are illegal and set err.
  - For stores, only 000, 001 and 010 are legal; 100 and 101 with req_wen=1 also set err.
- Alignment: H and HU require addr[0]=0; W requires addr[1:0]=00. Any violation sets err.
- FSM:
  - IDLE: req_ready=1. On req_valid & req_ready, latch wen, addr, wdata and byt_typ. Then go to WAIT with counter=WAIT_CYCLES, or go straight to ACCESS if WAIT_CYCLES=0.
  - WAIT: req_ready=0. The counter decrements each cycle. At counter==1, go to ACCESS.
  - ACCESS: one cycle, req_ready=0. Compute err.
    - Store with no err: write the selected byte lanes of word addr[ADDR_WIDTH-1:2]. SB writes lane addr[1:0], SH writes lanes {addr[1],0} and {addr[1],1}, SW writes all four lanes. Bytes are little-endian.
    - Load with no err: extract the selected lanes and sign- or zero-extend into rsp_rdata.
    - Any err: no write, and rsp_rdata=0.
    - Next state is RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1. On rsp_valid & rsp_ready, rsp_valid drops and the state returns to IDLE on the next edge.
- Latency: with rsp_ready tied to 1, req accept at edge N gives rsp_valid high in the cycle after edge N+WAIT_CYCLES+1. Total is WAIT_CYCLES+2 edges from accept to rsp_valid deassert.
- Ordering:
  - A new request is never accepted while a response is pending; there is no overlap.
  - req_valid while req_ready=0 is ignored, and the requester must hold the request.
- Load after store to the same word sees the stored data, because the write commits in ACCESS before any later read.
- Reset mid-operation: the FSM returns to IDLE immediately. A request still in WAIT is dropped with no array write. A write already committed in ACCESS persists.
- Array addressing wraps modulo 2^ADDR_WIDTH; there is no out-of-range error.

Decomposition:
- Shared package/header (alongside the existing constants header):
  - BYT_B, BYT_H, BYT_W, BYT_BU and BYT_HU localparams.
  - dmem state encoding (IDLE, WAIT, ACCESS, RESP).
  - WORD_WIDTH.
- Sub-module dmem_lane_align (combinational), containing:
  - err detection;
  - write byte-enable and shifted write-data generation;
  - read lane extraction and sign/zero extension.
- The top holds the FSM, the counter, the request latch and the array.

Test Plan:
- Reset then SW: addr=0x010, wdata=0x8081_82F3, WAIT_CYCLES=2, rsp_ready=1 -> rsp_valid 4 edges after accept, err=0, rdata=0. A following LW at addr 0x010 returns 0x8081_82F3.
- Sub-word loads from word 0x8081_82F3 at 0x010:
  - LB at 0x010 -> 0xFFFF_FFF3
  - LBU at 0x010 -> 0x0000_00F3
  - LH at 0x012 -> 0xFFFF_8081
  - LHU at 0x012 -> 0x0000_8081
- Sub-word stores: SB 0xAA at 0x011, then SH 0x1234 at 0x012 -> LW at 0x010 returns 0x1234_AAF3.
- Misaligned and illegal accesses:
  - LW at 0x013 -> err=1, rdata=0.
  - SH at 0x011 -> err=1, and the word is unchanged when read back.
  - byt_typ=111 -> err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stay stable, req_ready stays 0, and a second req_valid is not accepted until after the response handshake.
- Reset in WAIT: issue SW 0xDEAD_BEEF to 0x020 and assert rst_n=0 one cycle after accept -> outputs take reset values immediately, and a later LW at 0x020 returns the old contents. Also repeat the latency check with WAIT_CYCLES=0 -> rsp_valid 2 edges after accept.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: access-type codes, word width
// and the responder FSM state encoding.
package dmem_responder_pkg;

   localparam int unsigned WORD_WIDTH = 32;

   localparam logic [2:0] BYT_B  = 3'b000;
   localparam logic [2:0] BYT_H  = 3'b001;
   localparam logic [2:0] BYT_W  = 3'b010;
   localparam logic [2:0] BYT_BU = 3'b100;
   localparam logic [2:0] BYT_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for one data-memory access: error detection,
// store byte enables / replicated write data, and load extraction with extension.
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic                  wen_i,
   input  logic [1:0]            addr_i,
   input  logic [2:0]            byt_typ_i,
   input  logic [WORD_WIDTH-1:0] wdata_i,
   input  logic [WORD_WIDTH-1:0] rword_i,
   output logic                  err_o,
   output logic [3:0]            be_o,
   output logic [WORD_WIDTH-1:0] wdata_o,
   output logic [WORD_WIDTH-1:0] rdata_o
);

   logic [15:0] rlane;

   function automatic logic [31:0] extend(input logic [15:0] v, input logic half, input logic sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] r;
      b = signed'(v[7:0]);
      h = signed'(v);
      if (half) r = sgn ? 32'(h) : signed'({16'h0000, v});
      else      r = sgn ? 32'(b) : signed'({24'h000000, v[7:0]});
      return unsigned'(r);
   endfunction

   // Lane 0 of rlane is the addressed byte; halfwords are aligned so this also covers H/HU.
   assign rlane = 16'(rword_i >> {addr_i, 3'b000});

   always_comb begin
      err_o   = 1'b0;
      be_o    = 4'b0000;
      wdata_o = wdata_i;
      rdata_o = '0;
      case (byt_typ_i)
         BYT_B:   err_o = 1'b0;
         BYT_H:   err_o = addr_i[0];
         BYT_W:   err_o = |addr_i;
         BYT_BU:  err_o = wen_i;
         BYT_HU:  err_o = wen_i | addr_i[0];
         default: err_o = 1'b1;
      endcase
      if (!err_o) begin
         if (wen_i) begin
            // Replicating the low bytes lets the byte enables alone pick the lanes.
            case (byt_typ_i[1:0])
               2'b00: begin
                  be_o    = 4'b0001 << addr_i;
                  wdata_o = {4{wdata_i[7:0]}};
               end
               2'b01: begin
                  be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                  wdata_o = {2{wdata_i[15:0]}};
               end
               default: be_o = 4'b1111;
            endcase
         end else if (byt_typ_i[1:0] == 2'b10) begin
            rdata_o = rword_i;
         end else begin
            rdata_o = extend(rlane, byt_typ_i[0], ~byt_typ_i[2]);
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, a single
// ACCESS cycle on the word array, then a response held until the requester takes it.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WORD_WIDTH  = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORD_WIDTH-1:0] req_wdata,
   input  logic [2:0]            req_byt_typ,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORD_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);
   import dmem_responder_pkg::*;

   localparam int unsigned DEPTH     = 2 ** (ADDR_WIDTH - 2);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   dmem_state_e           state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  accept;

   logic                  wen_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WORD_WIDTH-1:0] wdata_q;
   logic [2:0]            typ_q;

   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-3:0] widx;
   logic [WORD_WIDTH-1:0] rword, wdata_lane, rdata_lane;
   logic [3:0]            be;
   logic                  lane_err;

   assign widx  = addr_q[ADDR_WIDTH-1:2];
   assign rword = mem[widx];

   dmem_lane_align u_align (
      .wen_i     (wen_q),
      .addr_i    (addr_q[1:0]),
      .byt_typ_i (typ_q),
      .wdata_i   (wdata_q),
      .rword_i   (rword),
      .err_o     (lane_err),
      .be_o      (be),
      .wdata_o   (wdata_lane),
      .rdata_o   (rdata_lane)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               cnt_d  = WAIT_INIT;
               if (WAIT_CYCLES == 0) state_d = ST_ACCESS;
               else                  state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            rdata_d = rdata_lane;
            err_d   = lane_err;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Request latch and array carry no reset; be is all-zero for loads and errors.
   always_ff @(posedge clk) begin
      if (accept) begin
         wen_q   <= req_wen;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         typ_q   <= req_byt_typ;
      end
      if (state_q == ST_ACCESS) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
         end
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random accesses against a byte-array
// model, on one instance with two wait states and one with none.
module tb_dmem_responder;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_valid0, req_wen, rsp_ready;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [2:0]    req_byt_typ;
   logic          req_ready, rsp_valid, rsp_err;
   logic [31:0]   rsp_rdata;
   logic          req_ready0, rsp_valid0, rsp_err0;
   logic [31:0]   rsp_rdata0;

   int total = 0;
   int bad   = 0;

   logic [7:0] mdl  [1024];
   logic [7:0] mdl0 [1024];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_WIDTH(AW), .WORD_WIDTH(32), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_byt_typ(req_byt_typ), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.ADDR_WIDTH(AW), .WORD_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_byt_typ(req_byt_typ), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
   );

   // Reference: byte-addressed memory; access size from the low type bits, bit 2 = unsigned.
   function automatic void model(input bit z, input logic wen, input logic [9:0] a,
                                 input logic [31:0] wd, input logic [2:0] t,
                                 output logic [31:0] rd, output logic e);
      int sz;
      logic [31:0] v;
      sz = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
      e  = (t[1:0] == 2'b11) || (t[2] && (t[1:0] == 2'b10 || wen)) || ((int'(a) % sz) != 0);
      rd = 32'h0;
      if (e) return;
      v = 32'h0;
      for (int i = 0; i < sz; i++) begin
         if (wen) begin
            if (z) mdl0[int'(a) + i] = wd[8*i +: 8];
            else   mdl[int'(a) + i]  = wd[8*i +: 8];
         end else begin
            if (z) v = v | (32'(mdl0[int'(a) + i]) << (8 * i));
            else   v = v | (32'(mdl[int'(a) + i]) << (8 * i));
         end
      end
      if (!wen) begin
         if (!t[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
         if (!t[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
         rd = v;
      end
   endfunction

   // One full transaction with rsp_ready high; lat = edges from accept until rsp_valid is seen.
   task automatic issue(input bit z, input logic wen, input logic [9:0] a, input logic [31:0] wd,
                        input logic [2:0] t, output logic [31:0] rd, output logic e, output int lat);
      int n;
      @(negedge clk);
      req_wen = wen; req_addr = a; req_wdata = wd; req_byt_typ = t;
      if (z) req_valid0 = 1'b1; else req_valid = 1'b1;
      n = 0;
      while (!(z ? req_ready0 : req_ready) && n < 40) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0; req_valid0 = 1'b0;
      lat = 0;
      while (!(z ? rsp_valid0 : rsp_valid) && lat < 40) begin @(posedge clk); #1; lat++; end
      rd = z ? rsp_rdata0 : rsp_rdata;
      e  = z ? rsp_err0 : rsp_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
      req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_byt_typ = 3'b010;
      repeat (3) @(posedge clk);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_preload();
      logic [31:0] rd, erd, wd;
      logic e, ee;
      int lat;
      for (int w = 0; w < 256; w++) begin
         wd = $urandom;
         model(1'b0, 1'b1, 10'(w * 4), wd, 3'b010, erd, ee);
         issue(1'b0, 1'b1, 10'(w * 4), wd, 3'b010, rd, e, lat);
         total++; if (e !== ee) begin bad++; $display("FAIL preload_err w=%0d got=%b want=%b", w, e, ee); end
      end
   endtask

   task automatic test_store_word();
      logic [31:0] rd, erd;
      logic e, ee;
      int lat;
      model(1'b0, 1'b1, 10'h010, 32'h8081_82F3, 3'b010, erd, ee);
      issue(1'b0, 1'b1, 10'h010, 32'h8081_82F3, 3'b010, rd, e, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d want=3", lat); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL sw_valid_drop got=%b want=0", rsp_valid); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL sw_err got=%b want=0", e); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h want=0", rd); end
      model(1'b0, 1'b0, 10'h010, 32'h0, 3'b010, erd, ee);
      issue(1'b0, 1'b0, 10'h010, 32'h0, 3'b010, rd, e, lat);
      total++; if (rd !== 32'h8081_82F3) begin bad++; $display("FAIL lw_after_sw got=%h want=808182f3", rd); end
   endtask

   task automatic test_subword_loads();
      logic [9:0]  ta [4] = '{10'h010, 10'h010, 10'h012, 10'h012};
      logic [2:0]  tt [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] tx [4] = '{32'hFFFF_FFF3, 32'h0000_00F3, 32'hFFFF_8081, 32'h0000_8081};
      logic [31:0] rd, erd;
      logic e, ee;
      int lat;
      for (int i = 0; i < 4; i++) begin
         model(1'b0, 1'b0, ta[i], 32'h0, tt[i], erd, ee);
         issue(1'b0, 1'b0, ta[i], 32'h0, tt[i], rd, e, lat);
         total++; if (rd !== tx[i] || e !== 1'b0) begin
            bad++; $display("FAIL subload_%0d got=%h/%b want=%h/0", i, rd, e, tx[i]);
         end
      end
   endtask

   task automatic test_subword_stores();
      logic [31:0] rd, erd;
      logic e, ee;
      int lat;
      model(1'b0, 1'b1, 10'h011, 32'h5555_55AA, 3'b000, erd, ee);
      issue(1'b0, 1'b1, 10'h011, 32'h5555_55AA, 3'b000, rd, e, lat);
      model(1'b0, 1'b1, 10'h012, 32'hFFFF_1234, 3'b001, erd, ee);
      issue(1'b0, 1'b1, 10'h012, 32'hFFFF_1234, 3'b001, rd, e, lat);
      model(1'b0, 1'b0, 10'h010, 32'h0, 3'b010, erd, ee);
      issue(1'b0, 1'b0, 10'h010, 32'h0, 3'b010, rd, e, lat);
      total++; if (rd !== 32'h1234_AAF3) begin bad++; $display("FAIL sb_sh_merge got=%h want=1234aaf3", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd, erd;
      logic e, ee;
      int lat;
      issue(1'b0, 1'b0, 10'h013, 32'h0, 3'b010, rd, e, lat);
      total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL lw_misaligned got=%h/%b want=0/1", rd, e); end
      issue(1'b0, 1'b1, 10'h011, 32'hFFFF_FFFF, 3'b001, rd, e, lat);
      total++; if (e !== 1'b1) begin bad++; $display("FAIL sh_misaligned got=%b want=1", e); end
      issue(1'b0, 1'b0, 10'h010, 32'h0, 3'b010, rd, e, lat);
      total++; if (rd !== 32'h1234_AAF3) begin bad++; $display("FAIL sh_err_nowrite got=%h want=1234aaf3", rd); end
      issue(1'b0, 1'b0, 10'h010, 32'h0, 3'b111, rd, e, lat);
      total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL typ111 got=%h/%b want=0/1", rd, e); end
      issue(1'b0, 1'b1, 10'h010, 32'hFFFF_FFFF, 3'b100, rd, e, lat);
      total++; if (e !== 1'b1) begin bad++; $display("FAIL sbu_store got=%b want=1", e); end
      issue(1'b0, 1'b0, 10'h010, 32'h0, 3'b010, rd, e, lat);
      total++; if (rd !== 32'h1234_AAF3) begin bad++; $display("FAIL sbu_err_nowrite got=%h want=1234aaf3", rd); end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, wd;
      logic [9:0]  a;
      logic [2:0]  t;
      logic        wen, e, ee;
      int lat;
      for (int i = 0; i < 150; i++) begin
         wen = 1'($urandom_range(0, 1));
         t   = 3'($urandom_range(0, 7));
         a   = 10'($urandom);
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         wd  = $urandom;
         model(1'b0, wen, a, wd, t, erd, ee);
         issue(1'b0, wen, a, wd, t, rd, e, lat);
         total++; if (rd !== erd || e !== ee || lat !== 3) begin
            bad++; $display("FAIL random_%0d wen=%b a=%h t=%b got=%h/%b/%0d want=%h/%b/3", i, wen, a, t, rd, e, lat, erd, ee);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd0, erd, rd;
      logic e0, ee, e;
      int n;
      model(1'b0, 1'b0, 10'h010, 32'h0, 3'b010, erd, ee);
      @(negedge clk);
      rsp_ready = 1'b0;
      req_wen = 1'b0; req_addr = 10'h010; req_wdata = 32'h0; req_byt_typ = 3'b010; req_valid = 1'b1;
      @(posedge clk); #1;
      req_wen = 1'b1; req_addr = 10'h014; req_wdata = 32'h0BAD_F00D;
      n = 0;
      while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
      rd0 = rsp_rdata; e0 = rsp_err;
      total++; if (rd0 !== erd || e0 !== 1'b0) begin bad++; $display("FAIL bp_first got=%h/%b want=%h/0", rd0, e0, erd); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++; if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_err !== e0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold_%0d got=%b/%h/%b/%b want=1/%h/%b/0", i, rsp_valid, rsp_rdata, rsp_err, req_ready, rd0, e0);
         end
      end
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got=%b/%b want=0/1", rsp_valid, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept got=%b want=0", req_ready); end
      model(1'b0, 1'b1, 10'h014, 32'h0BAD_F00D, 3'b010, erd, ee);
      n = 0;
      while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
      total++; if (n !== 3 || rsp_err !== 1'b0) begin bad++; $display("FAIL bp_second_rsp got=%0d/%b want=3/0", n, rsp_err); end
      @(posedge clk); #1;
      model(1'b0, 1'b0, 10'h014, 32'h0, 3'b010, erd, ee);
      issue(1'b0, 1'b0, 10'h014, 32'h0, 3'b010, rd, e, n);
      total++; if (rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL bp_second_data got=%h want=0badf00d", rd); end
   endtask

   task automatic test_reset_wait();
      logic [31:0] rd, erd;
      logic e, ee;
      int lat;
      @(negedge clk);
      req_wen = 1'b1; req_addr = 10'h020; req_wdata = 32'hDEAD_BEEF; req_byt_typ = 3'b010; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         bad++; $display("FAIL rst_wait_outputs got=%b/%b/%h/%b want=1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge clk); rst_n = 1'b1;
      model(1'b0, 1'b0, 10'h020, 32'h0, 3'b010, erd, ee);
      issue(1'b0, 1'b0, 10'h020, 32'h0, 3'b010, rd, e, lat);
      total++; if (rd !== erd) begin bad++; $display("FAIL rst_wait_nowrite got=%h want=%h", rd, erd); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd, erd;
      logic e, ee;
      int lat;
      model(1'b1, 1'b1, 10'h020, 32'hCAFE_F00D, 3'b010, erd, ee);
      issue(1'b1, 1'b1, 10'h020, 32'hCAFE_F00D, 3'b010, rd, e, lat);
      total++; if (lat !== 1 || e !== 1'b0) begin bad++; $display("FAIL zw_sw got=%0d/%b want=1/0", lat, e); end
      total++; if (rsp_valid0 !== 1'b0) begin bad++; $display("FAIL zw_valid_drop got=%b want=0", rsp_valid0); end
      model(1'b1, 1'b0, 10'h020, 32'h0, 3'b010, erd, ee);
      issue(1'b1, 1'b0, 10'h020, 32'h0, 3'b010, rd, e, lat);
      total++; if (rd !== 32'hCAFE_F00D || lat !== 1) begin bad++; $display("FAIL zw_lw got=%h/%0d want=cafef00d/1", rd, lat); end
      model(1'b1, 1'b0, 10'h022, 32'h0, 3'b101, erd, ee);
      issue(1'b1, 1'b0, 10'h022, 32'h0, 3'b101, rd, e, lat);
      total++; if (rd !== 32'h0000_CAFE || e !== 1'b0) begin bad++; $display("FAIL zw_lhu got=%h/%b want=0000cafe/0", rd, e); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_preload();
      test_store_word();
      test_subword_loads();
      test_subword_stores();
      test_errors();
      test_random();
      test_backpressure();
      test_reset_wait();
      test_zero_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
